// File: rtl/seg7_rx_monitor.sv
// Receive-side 7-segment monitor: synchronize, debounce, decode, and check the digit counting sequence.
// Optional macro SEG7_RX_ACTIVE_LOW_EN inverts segments_in for common-anode displays.
module seg7_rx_monitor #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned MAX_DIGIT     = 7,
   parameter int unsigned TIMEOUT       = 12000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] segments_in,
   output logic [3:0] digit_out,
   output logic       digit_valid,
   output logic       decode_err,
   output logic       seq_err,
   output logic       locked,
   output logic       stall,
   output logic [7:0] err_count
);

   localparam int unsigned SEG_W = 7;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned TMR_W = 24;
   localparam int unsigned ERR_W = 8;

   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [DIG_W-1:0] DIG_MAX    = DIG_W'(MAX_DIGIT);
   localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(TIMEOUT);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [SEG_W-1:0]   seg_raw;
   logic [SEG_W-1:0]   sync1_q, sync2_q, cand_q, cand_d, acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIG_W-1:0]   digit_q, digit_d, exp_q, exp_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               dv_q, dv_d, de_q, de_d, se_q, se_d, lk_q, lk_d, stall_q, stall_d;
   logic               accept;
   logic               legal;
   logic [DIG_W-1:0]   dec_digit;

`ifdef SEG7_RX_ACTIVE_LOW_EN
   assign seg_raw = ~segments_in;
`else
   assign seg_raw = segments_in;
`endif

   // Pattern-to-digit lookup; MSB flags a legal pattern.
   function automatic logic [DIG_W:0] decode(input logic [SEG_W-1:0] p);
      case (p)
         7'h3F:   decode = {1'b1, 4'd0};
         7'h06:   decode = {1'b1, 4'd1};
         7'h5B:   decode = {1'b1, 4'd2};
         7'h4F:   decode = {1'b1, 4'd3};
         7'h66:   decode = {1'b1, 4'd4};
         7'h6D:   decode = {1'b1, 4'd5};
         7'h7D:   decode = {1'b1, 4'd6};
         7'h07:   decode = {1'b1, 4'd7};
         7'h7F:   decode = {1'b1, 4'd8};
         7'h6F:   decode = {1'b1, 4'd9};
         default: decode = {1'b0, 4'd0};
      endcase
   endfunction

   // Digits at or beyond the wrap point restart the sequence at zero.
   function automatic logic [DIG_W-1:0] next_digit(input logic [DIG_W-1:0] d);
      next_digit = (d >= DIG_MAX) ? '0 : DIG_W'(d + DIG_W'(1));
   endfunction

   assign {legal, dec_digit} = decode(cand_q);

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      accept = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q != STABLE_MAX) begin
         cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
      if ((cnt_q == STABLE_MAX) && (cand_q != acc_q)) begin
         accept = 1'b1;
         acc_d  = cand_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_UNLOCKED;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_UNLOCKED: if (accept && legal)  state_d = ST_LOCKED;
         ST_LOCKED:   if (accept && !legal) state_d = ST_UNLOCKED;
         default:     state_d = ST_UNLOCKED;
      endcase
   end

   always_comb begin
      digit_d = digit_q;
      exp_d   = exp_q;
      dv_d    = 1'b0;
      de_d    = 1'b0;
      se_d    = 1'b0;
      tmr_d   = tmr_q;
      err_d   = err_q;
      if (accept) begin
         if (legal) begin
            digit_d = dec_digit;
            dv_d    = 1'b1;
            exp_d   = next_digit(dec_digit);
            se_d    = (state_q == ST_LOCKED) && (dec_digit != exp_q);
         end else begin
            de_d    = 1'b1;
         end
      end
      if (accept || (state_q == ST_UNLOCKED)) tmr_d = '0;
      else if (tmr_q != TMR_MAX)              tmr_d = TMR_W'(tmr_q + TMR_W'(1));
      if ((de_d || se_d) && (err_q != ERR_MAX)) err_d = ERR_W'(err_q + ERR_W'(1));
      lk_d    = (state_d == ST_LOCKED);
      stall_d = (state_d == ST_LOCKED) && (tmr_d == TMR_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         digit_q <= '0;
         exp_q   <= '0;
         tmr_q   <= '0;
         err_q   <= '0;
         dv_q    <= 1'b0;
         de_q    <= 1'b0;
         se_q    <= 1'b0;
         lk_q    <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         sync1_q <= seg_raw;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         digit_q <= digit_d;
         exp_q   <= exp_d;
         tmr_q   <= tmr_d;
         err_q   <= err_d;
         dv_q    <= dv_d;
         de_q    <= de_d;
         se_q    <= se_d;
         lk_q    <= lk_d;
         stall_q <= stall_d;
      end
   end

   assign digit_out   = digit_q;
   assign digit_valid = dv_q;
   assign decode_err  = de_q;
   assign seq_err     = se_q;
   assign locked      = lk_q;
   assign stall       = stall_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_rx_monitor.sv
// Scoreboard bench for seg7_rx_monitor: directed patterns push expected events, a monitor pops and compares.
module tb_seg7_rx_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] segments_in;
   logic [3:0] digit_out;
   logic       digit_valid, decode_err, seq_err, locked, stall;
   logic [7:0] err_count;

   typedef struct packed {
      logic       dv;
      logic       de;
      logic       se;
      logic [3:0] dg;
      logic       lk;
      logic [7:0] ec;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   seg7_rx_monitor #(.STABLE_CYCLES(4), .MAX_DIGIT(7), .TIMEOUT(100)) dut (
      .clk        (clk),
      .rst        (rst),
      .segments_in(segments_in),
      .digit_out  (digit_out),
      .digit_valid(digit_valid),
      .decode_err (decode_err),
      .seq_err    (seq_err),
      .locked     (locked),
      .stall      (stall),
      .err_count  (err_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG7_RX_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   task automatic expect_ev(input logic de, input logic se, input logic [3:0] dg,
                            input logic lk, input logic [7:0] ec);
      exp_t e;
      e.dv = ~de; e.de = de; e.se = se; e.dg = dg; e.lk = lk; e.ec = ec;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [6:0] p, input int hold);
      segments_in = enc(p);
      repeat (hold) @(negedge clk);
   endtask

   task automatic wait_event(output int n);
      n = -1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (digit_valid || decode_err) begin
            n = k;
            break;
         end
      end
   endtask

   // Monitor: every accept event pops one expectation; locked/err_count checked one cycle later.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (digit_valid || decode_err)) begin
            if (sb_q.size() == 0) begin
               check("unexpected_event", {30'd0, digit_valid, decode_err}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("digit_valid", digit_valid, e.dv);
               check("decode_err", decode_err, e.de);
               check("seq_err", seq_err, e.se);
               check("digit_out", digit_out, e.dg);
               @(negedge clk);
               check("locked", locked, e.lk);
               check("err_count", err_count, e.ec);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n2;
      logic [6:0] seq_p [8] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h3F};
      logic [3:0] seq_d [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};

      rst = 1'b1;
      segments_in = enc(7'h00);
      repeat (3) @(negedge clk);
      check("rst_digit_out", digit_out, 0);
      check("rst_digit_valid", digit_valid, 0);
      check("rst_decode_err", decode_err, 0);
      check("rst_seq_err", seq_err, 0);
      check("rst_locked", locked, 0);
      check("rst_stall", stall, 0);
      check("rst_err_count", err_count, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic decode with latency measurement
      expect_ev(0, 0, 4'd0, 1, 8'd0);
      drive(7'h3F, 0);
      wait_event(n);
      check("accept_latency", n, 7);
      repeat (15) @(negedge clk);

      // Full counting sequence with wrap
      for (int i = 0; i < 8; i++) begin
         expect_ev(0, 0, seq_d[i], 1, 8'd0);
         drive(seq_p[i], 20);
      end

      // Glitch rejection
      expect_ev(0, 0, 4'd1, 1, 8'd0);
      drive(7'h06, 20);
      drive(7'h5B, 3);
      drive(7'h06, 20);
      check("glitch_no_event", sb_q.size(), 0);
      expect_ev(0, 0, 4'd2, 1, 8'd0);
      drive(7'h5B, 20);

      // Sequence error then resync
      expect_ev(0, 1, 4'd5, 1, 8'd1);
      drive(7'h6D, 20);
      expect_ev(0, 0, 4'd6, 1, 8'd1);
      drive(7'h7D, 20);

      // Decode error unlocks, digit holds
      expect_ev(1, 0, 4'd6, 0, 8'd2);
      drive(7'h55, 20);

      // Relock on 9 and wait for stall
      expect_ev(0, 0, 4'd9, 1, 8'd2);
      drive(7'h6F, 0);
      wait_event(n);
      n2 = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (stall) begin
            n2 = k;
            break;
         end
      end
      check("stall_delay", n2, 100);
      expect_ev(0, 0, 4'd0, 1, 8'd2);
      drive(7'h3F, 0);
      wait_event(n);
      @(negedge clk);
      check("stall_clear", stall, 0);
      repeat (10) @(negedge clk);

      // Saturating error counter
      for (int i = 0; i < 300; i++) begin
         expect_ev(1, 0, 4'd0, 0, (3 + i > 255) ? 8'd255 : 8'(3 + i));
         drive((i % 2 == 0) ? 7'h55 : 7'h00, 10);
      end
      check("err_saturated", err_count, 8'd255);

      // Reset in the middle of a debounce
      expect_ev(0, 0, 4'd1, 1, 8'd255);
      drive(7'h06, 20);
      drive(7'h5B, 3);
      #2 rst = 1'b1;
      #1;
      check("midrst_digit_out", digit_out, 0);
      check("midrst_locked", locked, 0);
      check("midrst_err_count", err_count, 0);
      check("midrst_pulses", {29'd0, digit_valid, decode_err, seq_err}, 0);
      segments_in = enc(7'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_reset_no_event", sb_q.size(), 0);
      expect_ev(0, 0, 4'd0, 1, 8'd0);
      drive(7'h3F, 20);

      repeat (5) @(negedge clk);
      check("scoreboard_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
